// File: rtl/move_scanner.sv
// move_scanner: walks all 64 squares for one colour, hands each empty square to the
// shared updater and gathers the legal-move mask and count for the game controller / AI.
module move_scanner #(
   parameter int EMPTY      = 2,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic                   i_color,
   input  logic [0:7][0:7][1:0]   i_board,
   output logic                   o_up_start,
   output logic                   o_up_color,
   output logic [2:0]             o_row,
   output logic [2:0]             o_col,
   input  logic [4:0]             i_up_flip,
   input  logic                   i_up_done,
   output logic [63:0]            o_mask,
   output logic [6:0]             o_count,
   output logic                   o_has_move,
   output logic                   o_busy,
   output logic                   o_done
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [1:0] EMPTY_CODE = 2'(EMPTY);

   state_t      state_q;
   logic [5:0]  idx_q;
   logic        color_q;
   logic [63:0] mask_q;
   logic [6:0]  count_q;

   logic [1:0]  sq;
   logic        sq_empty;
   logic        last_sq;
   logic        legal;

   // idx[2:0] selects the row, idx[5:3] the column
   assign sq       = i_board[idx_q[2:0]][idx_q[5:3]];
   assign sq_empty = (sq == EMPTY_CODE);
   assign last_sq  = (idx_q == 6'd63);
   assign legal    = (i_up_flip != 5'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         color_q <= 1'b0;
         mask_q  <= '0;
         count_q <= '0;
      end else if (i_abort) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  color_q <= i_color;
                  mask_q  <= '0;
                  count_q <= '0;
                  idx_q   <= '0;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (sq_empty) begin
                  state_q <= S_WAIT;
               end else if (last_sq) begin
                  state_q <= S_DONE;
               end else begin
                  idx_q <= idx_q + 6'd1;
               end
            end
            S_WAIT: begin
               // the updater's answer is only consumed here; stray pulses elsewhere fall through
               if (i_up_done) begin
                  if (legal) begin
                     mask_q[idx_q] <= 1'b1;
                     count_q       <= count_q + 7'd1;
                  end
                  if (last_sq || (EARLY_EXIT && legal)) begin
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q + 6'd1;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_up_start = (state_q == S_ISSUE) && sq_empty && !i_abort;
   assign o_up_color = color_q;
   assign o_row      = idx_q[2:0];
   assign o_col      = idx_q[5:3];
   assign o_mask     = mask_q;
   assign o_count    = count_q;
   assign o_has_move = (count_q != 7'd0);
   assign o_busy     = (state_q != S_IDLE);
   assign o_done     = (state_q == S_DONE) && !i_abort;

endmodule

// File: tb/tb_move_scanner.sv
// Bench for move_scanner: a table of board scans against a behavioural updater
// (latency 3), plus hand-written abort and start/abort-collision sequences.
module tb_move_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n, start_a, start_b, abort, color;
   logic                 upd_done, inj_done;
   logic [4:0]           upd_flip, inj_flip;
   logic [0:7][0:7][1:0] board;
   logic                 up_done;
   logic [4:0]           up_flip;
   bit                   sel;

   logic        a_up_start, a_up_color, a_has, a_busy, a_done;
   logic [2:0]  a_row, a_col;
   logic [63:0] a_mask;
   logic [6:0]  a_count;
   logic        b_up_start, b_up_color, b_has, b_busy, b_done;
   logic [2:0]  b_row, b_col;
   logic [63:0] b_mask;
   logic [6:0]  b_count;

   logic        s_up_start, s_up_color, s_has, s_busy, s_done;
   logic [2:0]  s_row, s_col;
   logic [63:0] s_mask;
   logic [6:0]  s_count;

   assign up_done = upd_done | inj_done;
   assign up_flip = upd_flip | inj_flip;

   assign s_up_start = sel ? b_up_start : a_up_start;
   assign s_up_color = sel ? b_up_color : a_up_color;
   assign s_has      = sel ? b_has      : a_has;
   assign s_busy     = sel ? b_busy     : a_busy;
   assign s_done     = sel ? b_done     : a_done;
   assign s_row      = sel ? b_row      : a_row;
   assign s_col      = sel ? b_col      : a_col;
   assign s_mask     = sel ? b_mask     : a_mask;
   assign s_count    = sel ? b_count    : a_count;

   move_scanner #(.EMPTY(2), .EARLY_EXIT(1'b0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_abort(abort), .i_color(color),
      .i_board(board), .o_up_start(a_up_start), .o_up_color(a_up_color), .o_row(a_row),
      .o_col(a_col), .i_up_flip(up_flip), .i_up_done(up_done), .o_mask(a_mask),
      .o_count(a_count), .o_has_move(a_has), .o_busy(a_busy), .o_done(a_done));

   move_scanner #(.EMPTY(2), .EARLY_EXIT(1'b1)) u_dut_ee (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(abort), .i_color(color),
      .i_board(board), .o_up_start(b_up_start), .o_up_color(b_up_color), .o_row(b_row),
      .o_col(b_col), .i_up_flip(up_flip), .i_up_done(up_done), .o_mask(b_mask),
      .o_count(b_count), .o_has_move(b_has), .o_busy(b_busy), .o_done(b_done));

   int checks = 0;
   int errors = 0;

   // written only by the updater model process
   int starts, hits10, rcbad;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Othello flip count for a move of colour colr at (r,c) on the current board
   function automatic int flips(input int r, input int c, input logic colr);
      int n, k, rr, cc;
      bit run;
      n = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            k = 0; rr = r + dr; cc = c + dc; run = 1'b1;
            while (run) begin
               if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                  run = 1'b0;
               end else if (board[rr][cc] == {1'b0, ~colr}) begin
                  k++; rr += dr; cc += dc;
               end else begin
                  if (board[rr][cc] == {1'b0, colr}) n += k;
                  run = 1'b0;
               end
            end
         end
      end
      return n;
   endfunction

   task automatic set_board(input int scen);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            board[r][c] = (scen == 1) ? 2'd0 : 2'd2;
      if (scen == 0) begin
         board[3][3] = 2'd0; board[4][4] = 2'd0;
         board[3][4] = 2'd1; board[4][3] = 2'd1;
      end else if (scen == 3) begin
         board[7][5] = 2'd1; board[7][6] = 2'd0;
      end
   endtask

   // behavioural updater: answers each request 3 cycles after the request cycle
   initial begin
      logic [2:0] r, c;
      logic       uc;
      int         f;
      upd_done = 1'b0; upd_flip = '0; starts = 0; hits10 = 0; rcbad = 0;
      forever begin
         @(negedge clk);
         if (s_up_start) begin
            starts++;
            r = s_row; c = s_col; uc = s_up_color;
            if (!sel && r == 3'd2 && c == 3'd1) hits10++;
            f = flips(int'(r), int'(c), uc);
            repeat (3) @(posedge clk);
            #1;
            if (s_busy && {s_row, s_col} !== {r, c}) rcbad++;
            upd_flip = 5'(f); upd_done = 1'b1;
            @(posedge clk);
            #1;
            upd_done = 1'b0; upd_flip = '0;
         end
      end
   end

   typedef struct {
      int          scen;
      logic        colr;
      bit          early;
      bit          inj;
      logic [63:0] mask;
      int          cnt;
      int          nstart;
      int          cyc;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v, input int id);
      int cyc, sb, rb;
      sel = v.early; set_board(v.scen); color = v.colr;
      @(posedge clk); #1;
      sb = starts; rb = rcbad;
      if (v.early) start_b = 1'b1; else start_a = 1'b1;
      cyc = 1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; cyc = 2;
      chk($sformatf("v%0d_busy_after_start", id), 64'(s_busy), 64'd1);
      while (!s_done && cyc < 400) begin
         if (v.inj && cyc == 20) begin
            start_a = 1'b1; inj_done = 1'b1; inj_flip = 5'd5;
         end else begin
            start_a = 1'b0; inj_done = 1'b0; inj_flip = '0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start_a = 1'b0; inj_done = 1'b0; inj_flip = '0;
      chk($sformatf("v%0d_done_cycle", id), 64'(cyc), 64'(v.cyc));
      chk($sformatf("v%0d_mask", id), s_mask, v.mask);
      chk($sformatf("v%0d_count", id), 64'(s_count), 64'(v.cnt));
      chk($sformatf("v%0d_has_move", id), 64'(s_has), 64'(v.cnt != 0));
      chk($sformatf("v%0d_up_starts", id), 64'(starts - sb), 64'(v.nstart));
      chk($sformatf("v%0d_rowcol_stable", id), 64'(rcbad - rb), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_busy_after", id), {62'd0, s_done, s_busy}, 64'd0);
      chk($sformatf("v%0d_mask_held", id), s_mask, v.mask);
      chk($sformatf("v%0d_count_held", id), 64'(s_count), 64'(v.cnt));
   endtask

   initial begin
      int n, base, sb, done_cnt;
      vecs[0] = '{0, 1'b1, 1'b0, 1'b0,
                  (64'd1 << 19) | (64'd1 << 26) | (64'd1 << 37) | (64'd1 << 44), 4, 60, 246};
      vecs[1] = '{1, 1'b1, 1'b0, 1'b0, 64'd0, 0, 0, 66};
      vecs[2] = '{0, 1'b1, 1'b1, 1'b0, 64'd1 << 19, 1, 20, 82};
      vecs[3] = '{0, 1'b0, 1'b0, 1'b0,
                  (64'd1 << 20) | (64'd1 << 29) | (64'd1 << 34) | (64'd1 << 43), 4, 60, 246};
      vecs[4] = '{2, 1'b1, 1'b0, 1'b0, 64'd0, 0, 64, 258};
      vecs[5] = '{3, 1'b1, 1'b0, 1'b0, 64'd1 << 63, 1, 62, 252};
      vecs[6] = '{1, 1'b1, 1'b0, 1'b1, 64'd0, 0, 0, 66};

      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; color = 1'b1;
      inj_done = 1'b0; inj_flip = '0; sel = 1'b0;
      set_board(0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {a_mask, a_count, a_has, a_busy, a_done, a_up_start, a_up_color, a_row, a_col}, 64'd0);
      chk("reset_outputs_ee", {b_mask, b_count, b_has, b_busy, b_done, b_up_start, b_up_color, b_row, b_col}, 64'd0);
      chk("reset_count", 64'(a_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // abort while waiting on the updater at idx 10, then a late done arrives
      sel = 1'b0; set_board(0); color = 1'b1;
      base = hits10;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      n = 0;
      while (hits10 == base && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_reached_idx10", 64'(hits10 - base), 64'd1);
      sb = starts;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 64'(a_busy), 64'd0);
      chk("abort_count", 64'(a_count), 64'd0);
      chk("abort_mask", a_mask, 64'd0);
      done_cnt = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (a_done) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_no_new_requests", 64'(starts - sb), 64'd0);
      chk("abort_late_done_ignored", {a_count, a_has, a_busy}, 64'd0);

      // start and abort together in idle: stays idle
      start_a = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; abort = 1'b0;
      chk("start_abort_collision_busy", 64'(a_busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("start_abort_collision_idle", {a_busy, a_done, a_up_start}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/move_scanner.md
# move_scanner

Legal-move scheduler for the Othello datapath. It owns the shared `updater` for one scan: it walks all 64 squares for a given colour, skips occupied squares locally, and issues one updater request per empty square. It collects the results into a 64-bit legal-move mask and a move count. The game controller uses it for pass/end-of-game detection, and the AI uses it for move enumeration. The game controller muxes the updater request lines from this block while its own state selects the scanner.

## Interface
Parameters:
- `EMPTY`, default 2: board encoding of an empty square.
- `EARLY_EXIT`, default 0: when 1, the scan stops at the first legal square (pass detection only).

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  one-cycle pulse; begins a scan. Ignored while busy.
- `i_abort`  in  1  abandons the scan and returns to idle.
- `i_color`  in  1  colour to test; latched on start.
- `i_board`  in  2×[0:7][0:7]  current board; must be held stable for the whole scan.
- `o_up_start`  out  1  one-cycle request pulse to the updater.
- `o_up_color`  out  1  latched colour, to the updater.
- `o_row`, `o_col`  out  3 each  square under test: `o_row = idx[2:0]`, `o_col = idx[5:3]`.
- `i_up_flip`  in  5  flip count from the updater, valid with `i_up_done`.
- `i_up_done`  in  1  one-cycle updater completion pulse.
- `o_mask`  out  64  bit `idx` set when square `idx` is legal.
- `o_count`  out  7  number of legal squares found.
- `o_has_move`  out  1  `o_count != 0`.
- `o_busy`  out  1  high in every state except `S_IDLE`.
- `o_done`  out  1  one-cycle pulse when the scan completes.

## Operation
- Registers: 6-bit index `idx`, colour, mask, count, and a 2-bit state.
- States:
  - `S_IDLE`: on `i_start`, latch the colour, clear mask and count, set `idx=0`, go to `S_ISSUE`.
  - `S_ISSUE`:
    - If `i_board[idx[2:0]][idx[5:3]] != EMPTY`, treat the square as not legal. If `idx==63`, go to `S_DONE`; otherwise increment `idx` and stay. This costs 1 cycle.
    - Otherwise assert `o_up_start` for exactly this cycle and go to `S_WAIT`.
  - `S_WAIT`: on `i_up_done`:
    - If `i_up_flip != 0`, set `mask[idx]` and increment count.
    - Then go to `S_DONE` if `idx==63`, or if `EARLY_EXIT` is set and this square was legal. Otherwise increment `idx` and return to `S_ISSUE`.
  - `S_DONE`: assert `o_done` for one cycle, go to `S_IDLE`.
- Result hold: `o_mask`, `o_count` and `o_has_move` hold their values after done until the next start.
- Count width: 7 bits, max 64, never wraps.
- `idx` does not wrap: increment happens only when `idx < 63`.
- `o_row`/`o_col` always reflect `idx`, and are stable from the `o_up_start` cycle through `i_up_done`.

## Timing
- Reset values: state `S_IDLE`, `idx=0`, `o_mask=0`, `o_count=0`, `o_has_move=0`, `o_busy=0`, `o_done=0`, `o_up_start=0`, `o_up_color=0`, `o_row=0`, `o_col=0`.
- Start sampled in `S_IDLE` at edge T: `o_busy` is high from T+1. The first `o_up_start` occurs at T+1 at the earliest.
- Scan latency from start to `o_done`: 1 + (occupied squares × 1) + Σ over empty squares of (1 + updater latency) + 1 cycles.
  - Updater latency is the number of cycles from the `o_up_start` cycle to the `i_up_done` cycle.
- Exactly one `o_up_start` per empty square visited. Never two outstanding requests.
- `i_up_done` outside `S_WAIT` is ignored.
- `i_start` while busy is ignored.
- `i_abort`:
  - Highest priority in any state: next state is `S_IDLE`, mask and count are cleared, no `o_done` is generated.
  - If `i_abort` coincides with `i_start` in `S_IDLE`, the block stays idle.
  - An in-flight updater response after abort is ignored.
- Reset mid-scan clears everything immediately (asynchronous).

## Test plan
- Reset, then check: all outputs at the listed reset values; `o_busy=0`.
- Initial board (`[3][3]`, `[4][4]` WHITE; `[3][4]`, `[4][3]` BLACK), `i_color=1`, behavioural updater with latency 3:
  - Required: `o_mask` has exactly bits 26, 19, 44, 37 set; `o_count=4`; `o_has_move=1`.
  - Required: exactly 60 `o_up_start` pulses.
  - Required: `o_done` at cycle 1 + 4 + 60·4 + 1 = 246 after the start edge.
- Full board with no empty squares: no `o_up_start` pulses; `o_done` at cycle 66; `o_count=0`; `o_has_move=0`.
- `EARLY_EXIT=1` on the initial board with colour 1: the scan stops after idx 19; `o_mask` = bit 19 only; `o_count=1`.
- `i_abort` asserted during `S_WAIT` at idx 10, followed by a late `i_up_done`: block returns to `S_IDLE`, no `o_done`, `o_count=0`, late done ignored.
- `i_start` pulsed mid-scan and `i_up_done` pulsed during `S_ISSUE`: neither changes the result from the second scenario.
